// File: rtl/matrix_pkg.sv
// Shared constants, state type and slot helpers for the packed 5x5 matrix bus.
// Used by matrix_loader and the matrix arithmetic units.
package matrix_pkg;

  localparam int DIM_MAX = 5;
  localparam int ELEM_W  = 8;
  localparam int MAT_W   = DIM_MAX * DIM_MAX * ELEM_W;
  localparam int DIM_W   = 3;
  localparam int CNT_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ml_state_e;

  function automatic int slot_off(input int i, input int j);
    return (i * DIM_MAX + j) * ELEM_W;
  endfunction

  function automatic logic dims_legal(input logic [DIM_W-1:0] d);
    return (d != '0) && (int'(d) <= DIM_MAX);
  endfunction

endpackage

// File: rtl/matrix_rc_counter.sv
// Row/column walker for a row-major element stream; col wraps at mat_n-1.
// last flags the element that completes an m x n load.
module matrix_rc_counter
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             adv,
  input  logic [DIM_W-1:0] mat_m,
  input  logic [DIM_W-1:0] mat_n,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] total;

  // Legal dims are at most 5x5, so the product always fits in CNT_W bits.
  assign total = CNT_W'(mat_m) * CNT_W'(mat_n);
  assign last  = (count == total - CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row   <= '0;
      col   <= '0;
      count <= '0;
    end else if (clr) begin
      row   <= '0;
      col   <= '0;
      count <= '0;
    end else if (adv) begin
      count <= count + CNT_W'(1);
      if (col == mat_n - DIM_W'(1)) begin
        col <= '0;
        row <= row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Packs an m x n row-major element stream into the 200-bit matrix bus.
// Optional inter-element watchdog enabled by MATRIX_LOADER_TIMEOUT_EN.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic              elem_valid,
  input  logic [ELEM_W-1:0] elem_data,
  output logic              elem_ready,
  output logic [MAT_W-1:0]  matrix,
  output logic [DIM_W-1:0]  mat_m,
  output logic [DIM_W-1:0]  mat_n,
  output logic [CNT_W-1:0]  elem_count,
  output logic              busy,
  output logic              done,
  output logic              load_error
);

  ml_state_e        state_q, state_d;
  logic [DIM_W-1:0] row, col;
  logic             last;
  logic             xfer, start_ok, start_bad, timeout;

  assign elem_ready = (state_q == ST_LOAD);
  assign busy       = (state_q == ST_LOAD);
  assign done       = (state_q == ST_DONE);
  assign xfer       = elem_valid && elem_ready;
  assign start_ok   = start && (state_q != ST_LOAD) && dims_legal(dim_m) && dims_legal(dim_n);
  assign start_bad  = start && (state_q != ST_LOAD) && !(dims_legal(dim_m) && dims_legal(dim_n));

`ifdef MATRIX_LOADER_TIMEOUT_EN
  localparam logic [26:0] TO_LAST = 27'(TIMEOUT_CYCLES - 1);
  logic [26:0] idle_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          idle_cnt <= '0;
    else if (state_q != ST_LOAD || xfer) idle_cnt <= '0;
    else                                 idle_cnt <= idle_cnt + 27'd1;
  end

  assign timeout = (state_q == ST_LOAD) && !xfer && (idle_cnt == TO_LAST);
`else
  // No watchdog: constant-false for any sane TIMEOUT_CYCLES.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  matrix_rc_counter u_rc (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok || timeout),
    .adv   (xfer),
    .mat_m (mat_m),
    .mat_n (mat_n),
    .row   (row),
    .col   (col),
    .count (elem_count),
    .last  (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start_ok) state_d = ST_LOAD;
      ST_LOAD: begin
        if (timeout)          state_d = ST_IDLE;
        else if (xfer && last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      matrix     <= '0;
      mat_m      <= '0;
      mat_n      <= '0;
      load_error <= 1'b0;
    end else begin
      load_error <= start_bad || timeout;
      if (start_ok) begin
        matrix <= '0;
        mat_m  <= dim_m;
        mat_n  <= dim_n;
      end else if (timeout) begin
        matrix <= '0;
      end else if (xfer) begin
        for (int i = 0; i < DIM_MAX; i++)
          for (int j = 0; j < DIM_MAX; j++)
            if (int'(row) == i && int'(col) == j)
              matrix[slot_off(i, j) +: ELEM_W] <= elem_data;
      end
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Randomized self-checking bench for matrix_loader against a cycle-level
// reference model that places elements by index arithmetic.
module tb_matrix_loader;
  import matrix_pkg::*;

  typedef logic [MAT_W-1:0] w_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] dim_m = '0, dim_n = '0;
  logic       elem_valid = 1'b0;
  logic [7:0] elem_data = '0;
  logic       elem_ready, busy, done, load_error;
  w_t         matrix;
  logic [2:0] mat_m, mat_n;
  logic [4:0] elem_count;

  matrix_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .dim_m(dim_m), .dim_n(dim_n),
    .elem_valid(elem_valid), .elem_data(elem_data), .elem_ready(elem_ready),
    .matrix(matrix), .mat_m(mat_m), .mat_n(mat_n), .elem_count(elem_count),
    .busy(busy), .done(done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 loading, 2 done.
  int         ms = 0, mm = 0, mn = 0, mcnt = 0, midle = 0;
  logic       merr = 1'b0;
  logic [7:0] mmat [25];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms = 0; mm = 0; mn = 0; mcnt = 0; midle = 0; merr = 1'b0;
      foreach (mmat[k]) mmat[k] = 8'h00;
    end else begin
      merr = 1'b0;
      if (ms != 1) begin
        if (start) begin
          if (int'(dim_m) >= 1 && int'(dim_m) <= 5 && int'(dim_n) >= 1 && int'(dim_n) <= 5) begin
            ms = 1; mm = int'(dim_m); mn = int'(dim_n); mcnt = 0; midle = 0;
            foreach (mmat[k]) mmat[k] = 8'h00;
          end else begin
            merr = 1'b1;
          end
        end
      end else if (elem_valid) begin
        mmat[(mcnt / mn) * 5 + (mcnt % mn)] = elem_data;
        mcnt++;
        midle = 0;
        if (mcnt == mm * mn) ms = 2;
      end else begin
`ifdef MATRIX_LOADER_TIMEOUT_EN
        if (midle == 15) begin
          ms = 0; mcnt = 0; midle = 0; merr = 1'b1;
          foreach (mmat[k]) mmat[k] = 8'h00;
        end else begin
          midle++;
        end
`endif
      end
    end
  end

  function automatic w_t pack();
    w_t r = '0;
    for (int k = 0; k < 25; k++) r[k*8 +: 8] = mmat[k];
    return r;
  endfunction

  task automatic chk(input string tag, input w_t got, input w_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("matrix",     matrix,            pack());
    chk("mat_m",      w_t'(mat_m),       w_t'(mm));
    chk("mat_n",      w_t'(mat_n),       w_t'(mn));
    chk("elem_count", w_t'(elem_count),  w_t'(mcnt));
    chk("busy",       w_t'(busy),        w_t'(ms == 1));
    chk("elem_ready", w_t'(elem_ready),  w_t'(ms == 1));
    chk("done",       w_t'(done),        w_t'(ms == 2));
    chk("load_error", w_t'(load_error),  w_t'(merr));
  endtask

  task automatic tick(input logic s, input int dm, input int dn, input logic v, input logic [7:0] d);
    start = s; dim_m = 3'(dm); dim_n = 3'(dn); elem_valid = v; elem_data = d;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dm, dn;
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;
    @(negedge clk);
    check_all();

    // 2x3, elements 1..6 back to back; valid kept high into DONE
    tick(1, 2, 3, 0, 8'h00);
    for (int k = 1; k <= 6; k++) tick(0, 2, 3, 1, 8'(k));
    tick(0, 2, 3, 1, 8'h77);
    tick(0, 0, 0, 0, 8'h00);

    // illegal dims from DONE
    tick(1, 0, 3, 0, 8'h00);
    tick(0, 0, 0, 0, 8'h00);
    tick(1, 2, 6, 0, 8'h00);
    tick(1, 7, 2, 0, 8'h00);
    tick(0, 0, 0, 0, 8'h00);

    // 5x5 with valid toggling; stall cycles carry junk data
    tick(1, 5, 5, 0, 8'h00);
    for (int k = 0; k < 50; k++)
      tick(0, 5, 5, (k % 2) == 0, ((k % 2) == 0) ? 8'(255 - k / 2) : 8'($urandom));
    tick(0, 0, 0, 0, 8'h00);

    // 3x3: start mid-load ignored, then async reset mid-cycle
    tick(1, 3, 3, 0, 8'h00);
    for (int k = 0; k < 4; k++) tick(0, 3, 3, 1, 8'($urandom));
    tick(1, 3, 3, 1, 8'($urandom));
    #2;
    start = 1'b0; elem_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    check_all();

    // 1x1 then reload 2x2 from DONE
    tick(1, 1, 1, 0, 8'h00);
    tick(0, 1, 1, 1, 8'hA5);
    tick(0, 0, 0, 0, 8'h00);
    tick(1, 2, 2, 0, 8'h00);
    for (int k = 0; k < 4; k++) tick(0, 2, 2, 1, 8'($urandom));
    tick(0, 0, 0, 0, 8'h00);

    // random loads with random stalls and stray starts
    for (int t = 0; t < 8; t++) begin
      dm = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 5));
      dn = int'($urandom_range(1, 5));
      tick(1, dm, dn, 0, 8'h00);
      for (int c = 0; c < 60; c++)
        tick($urandom_range(0, 9) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             $urandom_range(0, 3) != 0, 8'($urandom));
    end

`ifdef MATRIX_LOADER_TIMEOUT_EN
    // stall a 2x2 load after two elements until the watchdog fires
    tick(1, 2, 2, 0, 8'h00);
    tick(0, 2, 2, 1, 8'h11);
    tick(0, 2, 2, 1, 8'h22);
    for (int c = 0; c < 20; c++) tick(0, 0, 0, 0, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
